// File: rtl/game_session_ctrl_pkg.sv
// Shared definitions for the game session controller: field widths and FSM state encoding.
package game_session_ctrl_pkg;

  localparam int ROUND_W = 4;
  localparam int SCORE_W = 8;
  localparam int PID_W   = 3;

  typedef enum logic [2:0] {
    IDLE,
    READY,
    PLAY,
    RESULT,
    LOGOUT
  } state_t;

endpackage

// File: rtl/game_session_ctrl_session_timer.sv
// Inactivity timer: counts enabled cycles and flags the last allowed idle cycle.
module game_session_ctrl_session_timer #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign terminal = enable && (count == LAST);

endmodule

// File: rtl/game_session_ctrl.sv
// Game session controller: latches the logged-in player, sequences rounds, keeps the
// win score and hands logout requests back to Authentication.
module game_session_ctrl
  import game_session_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int MAX_ROUNDS     = 8,
  parameter int GUEST_ROUNDS   = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               LoggedIn,
  input  logic [PID_W-1:0]   PlayerID_from_pswd,
  input  logic               isGuest_from_PSWD,
  input  logic               StartBtn,
  input  logic               LogoutBtn,
  input  logic               RoundDone,
  input  logic               RoundWin,
  output logic               logout_from_gamectrl,
  output logic               GameStart,
  output logic               Playing,
  output logic [PID_W-1:0]   ActivePlayerID,
  output logic [SCORE_W-1:0] Score,
  output logic [ROUND_W-1:0] RoundCount
);

  state_t             state;
  logic               isGuest;
  logic               timerClear;
  logic               timerEnable;
  logic               timeout;
  logic [ROUND_W-1:0] roundLimit;

  // Timer only runs in READY; any other state (or a round start) restarts it from zero.
  assign timerEnable = (state == READY);
  assign timerClear  = (state != READY) || StartBtn;
  assign roundLimit  = isGuest ? ROUND_W'(GUEST_ROUNDS) : ROUND_W'(MAX_ROUNDS);

  game_session_ctrl_session_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) sessionTimer (
    .clk     (clk),
    .rst     (rst),
    .clear   (timerClear),
    .enable  (timerEnable),
    .terminal(timeout)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state                <= IDLE;
      isGuest              <= 1'b0;
      ActivePlayerID       <= '0;
      Score                <= '0;
      RoundCount           <= '0;
      GameStart            <= 1'b0;
      Playing              <= 1'b0;
      logout_from_gamectrl <= 1'b0;
    end else begin
      GameStart            <= 1'b0;
      logout_from_gamectrl <= 1'b0;
      Playing              <= 1'b0;
      case (state)
        IDLE: begin
          if (LoggedIn) begin
            ActivePlayerID <= PlayerID_from_pswd;
            isGuest        <= isGuest_from_PSWD;
            Score          <= '0;
            RoundCount     <= '0;
            state          <= READY;
          end
        end
        READY: begin
          if (!LoggedIn) begin
            ActivePlayerID <= '0;
            state          <= IDLE;
          end else if (LogoutBtn || timeout) begin
            logout_from_gamectrl <= 1'b1;
            state                <= LOGOUT;
          end else if (StartBtn) begin
            GameStart  <= 1'b1;
            Playing    <= 1'b1;
            RoundCount <= RoundCount + 1'b1;
            state      <= PLAY;
          end
        end
        PLAY: begin
          Playing <= 1'b1;
          if (!LoggedIn) begin
            Playing        <= 1'b0;
            ActivePlayerID <= '0;
            state          <= IDLE;
          end else if (LogoutBtn) begin
            // An abort discards any result arriving in the same cycle.
            Playing              <= 1'b0;
            logout_from_gamectrl <= 1'b1;
            state                <= LOGOUT;
          end else if (RoundDone) begin
            Playing <= 1'b0;
            if (RoundWin && (Score != {SCORE_W{1'b1}})) begin
              Score <= Score + 1'b1;
            end
            state <= RESULT;
          end
        end
        RESULT: begin
          if (!LoggedIn) begin
            ActivePlayerID <= '0;
            state          <= IDLE;
          end else if (RoundCount >= roundLimit) begin
            logout_from_gamectrl <= 1'b1;
            state                <= LOGOUT;
          end else begin
            state <= READY;
          end
        end
        LOGOUT: begin
          if (!LoggedIn) begin
            ActivePlayerID <= '0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_game_session_ctrl.sv
// Scoreboard bench for game_session_ctrl: stimulus queues expected events, a negedge
// monitor compares them whenever the DUT pulses or the stimulus requests a probe.
module tb_game_session_ctrl;

  localparam int K_GS = 0;
  localparam int K_LO = 1;
  localparam int K_PR = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       LoggedIn = 1'b0;
  logic [2:0] PlayerID = 3'd0;
  logic       isGuest = 1'b0;
  logic       StartBtn = 1'b0;
  logic       LogoutBtn = 1'b0;
  logic       RoundDone = 1'b0;
  logic       RoundWin = 1'b0;
  logic       probe = 1'b0;

  logic       logout_from_gamectrl;
  logic       GameStart;
  logic       Playing;
  logic [2:0] ActivePlayerID;
  logic [7:0] Score;
  logic [3:0] RoundCount;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    string      name;
    int         kind;
    logic       lo;
    logic       gs;
    logic       play;
    logic [2:0] pid;
    logic [7:0] score;
    logic [3:0] rc;
  } exp_t;

  exp_t expQ[$];
  exp_t leftover;

  game_session_ctrl #(
    .TIMEOUT_CYCLES(64),
    .MAX_ROUNDS    (8),
    .GUEST_ROUNDS  (3)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .LoggedIn            (LoggedIn),
    .PlayerID_from_pswd  (PlayerID),
    .isGuest_from_PSWD   (isGuest),
    .StartBtn            (StartBtn),
    .LogoutBtn           (LogoutBtn),
    .RoundDone           (RoundDone),
    .RoundWin            (RoundWin),
    .logout_from_gamectrl(logout_from_gamectrl),
    .GameStart           (GameStart),
    .Playing             (Playing),
    .ActivePlayerID      (ActivePlayerID),
    .Score               (Score),
    .RoundCount          (RoundCount)
  );

  always #5 clk = ~clk;

  function automatic string kindName(input int kind);
    if (kind == K_GS) return "GameStart";
    if (kind == K_LO) return "logout";
    return "probe";
  endfunction

  task automatic push(input string name, input int kind, input logic lo, input logic gs,
                      input logic play, input logic [2:0] pid, input logic [7:0] score,
                      input logic [3:0] rc);
    exp_t e;
    e.name  = name;
    e.kind  = kind;
    e.lo    = lo;
    e.gs    = gs;
    e.play  = play;
    e.pid   = pid;
    e.score = score;
    e.rc    = rc;
    expQ.push_back(e);
  endtask

  task automatic check(input int kind);
    exp_t e;
    vectors++;
    if (expQ.size() == 0) begin
      miscompares++;
      $display("FAIL unexpected_%s: got lo=%0b gs=%0b play=%0b pid=%0d score=%0d rounds=%0d, need no event",
               kindName(kind), logout_from_gamectrl, GameStart, Playing, ActivePlayerID, Score, RoundCount);
      return;
    end
    e = expQ.pop_front();
    if (e.kind != kind || logout_from_gamectrl !== e.lo || GameStart !== e.gs || Playing !== e.play ||
        ActivePlayerID !== e.pid || Score !== e.score || RoundCount !== e.rc) begin
      miscompares++;
      $display("FAIL %s: got %s lo=%0b gs=%0b play=%0b pid=%0d score=%0d rounds=%0d, need %s lo=%0b gs=%0b play=%0b pid=%0d score=%0d rounds=%0d",
               e.name, kindName(kind), logout_from_gamectrl, GameStart, Playing, ActivePlayerID, Score,
               RoundCount, kindName(e.kind), e.lo, e.gs, e.play, e.pid, e.score, e.rc);
    end else begin
      $display("ok   %s: %s lo=%0b gs=%0b play=%0b pid=%0d score=%0d rounds=%0d",
               e.name, kindName(kind), e.lo, e.gs, e.play, e.pid, e.score, e.rc);
    end
  endtask

  always @(negedge clk) begin
    if (GameStart) check(K_GS);
    if (logout_from_gamectrl) check(K_LO);
    if (probe) check(K_PR);
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic doProbe(input string name, input logic lo, input logic gs, input logic play,
                         input logic [2:0] pid, input logic [7:0] score, input logic [3:0] rc);
    push(name, K_PR, lo, gs, play, pid, score, rc);
    probe = 1'b1;
    @(negedge clk);
    #1;
    probe = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // One full round from READY; scoreBefore and rc are the hand-computed values for this round.
  task automatic doRound(input logic [2:0] pid, input logic win, input logic [7:0] scoreBefore,
                         input logic [3:0] rc, input logic last);
    push($sformatf("start_p%0d_r%0d", pid, rc), K_GS, 1'b0, 1'b1, 1'b1, pid, scoreBefore, rc);
    StartBtn = 1'b1;
    cyc(1);
    StartBtn = 1'b0;
    cyc(2);
    RoundDone = 1'b1;
    RoundWin  = win;
    cyc(1);
    RoundDone = 1'b0;
    RoundWin  = 1'b0;
    if (last) push($sformatf("limitLogout_p%0d", pid), K_LO, 1'b1, 1'b0, 1'b0, pid,
                   scoreBefore + 8'(win), rc);
    cyc(1);
  endtask

  initial begin
    // Reset and a reset asserted in the middle of a round.
    cyc(2);
    rst = 1'b1;
    cyc(1);
    doProbe("resetState", 0, 0, 0, 3'd0, 8'd0, 4'd0);
    LoggedIn = 1'b1;
    PlayerID = 3'd5;
    cyc(1);
    push("preResetStart", K_GS, 0, 1, 1, 3'd5, 8'd0, 4'd1);
    StartBtn = 1'b1;
    cyc(1);
    StartBtn = 1'b0;
    cyc(1);
    #3;
    rst = 1'b0;
    LoggedIn = 1'b0;
    doProbe("asyncResetMidPlay", 0, 0, 0, 3'd0, 8'd0, 4'd0);
    cyc(1);
    rst = 1'b1;
    StartBtn = 1'b1;
    LogoutBtn = 1'b1;
    cyc(1);
    StartBtn = 1'b0;
    LogoutBtn = 1'b0;
    RoundDone = 1'b1;
    RoundWin = 1'b1;
    cyc(1);
    RoundDone = 1'b0;
    RoundWin = 1'b0;
    cyc(1);
    doProbe("idleIgnoresButtons", 0, 0, 0, 3'd0, 8'd0, 4'd0);

    // Registered player, eight winning rounds.
    LoggedIn = 1'b1;
    PlayerID = 3'd3;
    isGuest = 1'b0;
    cyc(1);
    for (int r = 1; r <= 8; r++) doRound(3'd3, 1'b1, 8'(r - 1), 4'(r), r == 8);
    cyc(3);
    doProbe("logoutHold", 0, 0, 0, 3'd3, 8'd8, 4'd8);
    LoggedIn = 1'b0;
    cyc(1);
    doProbe("logoutToIdle", 0, 0, 0, 3'd0, 8'd8, 4'd8);

    // Guest: three rounds, only the second won.
    LoggedIn = 1'b1;
    PlayerID = 3'd6;
    isGuest = 1'b1;
    cyc(1);
    doRound(3'd6, 1'b0, 8'd0, 4'd1, 1'b0);
    doRound(3'd6, 1'b1, 8'd0, 4'd2, 1'b0);
    doRound(3'd6, 1'b0, 8'd1, 4'd3, 1'b1);
    cyc(1);
    LoggedIn = 1'b0;
    isGuest = 1'b0;
    cyc(1);
    doProbe("guestLogoutIdle", 0, 0, 0, 3'd0, 8'd1, 4'd3);

    // Inactivity: pulse exactly 64 cycles after the login edge, counters cleared.
    LoggedIn = 1'b1;
    PlayerID = 3'd2;
    cyc(1);
    cyc(63);
    push("inactivityTimeout", K_LO, 1, 0, 0, 3'd2, 8'd0, 4'd0);
    cyc(1);
    cyc(1);
    doProbe("timeoutSinglePulse", 0, 0, 0, 3'd2, 8'd0, 4'd0);
    LoggedIn = 1'b0;
    cyc(1);

    // Logout collides with RoundDone+RoundWin, then with StartBtn.
    LoggedIn = 1'b1;
    PlayerID = 3'd7;
    cyc(1);
    doRound(3'd7, 1'b1, 8'd0, 4'd1, 1'b0);
    push("startRound2", K_GS, 0, 1, 1, 3'd7, 8'd1, 4'd2);
    StartBtn = 1'b1;
    cyc(1);
    StartBtn = 1'b0;
    cyc(1);
    LogoutBtn = 1'b1;
    RoundDone = 1'b1;
    RoundWin = 1'b1;
    push("logoutBeatsDone", K_LO, 1, 0, 0, 3'd7, 8'd1, 4'd2);
    cyc(1);
    LogoutBtn = 1'b0;
    RoundDone = 1'b0;
    RoundWin = 1'b0;
    cyc(1);
    doProbe("scoreHeld", 0, 0, 0, 3'd7, 8'd1, 4'd2);
    LoggedIn = 1'b0;
    cyc(1);
    LoggedIn = 1'b1;
    PlayerID = 3'd1;
    cyc(1);
    StartBtn = 1'b1;
    LogoutBtn = 1'b1;
    push("logoutBeatsStart", K_LO, 1, 0, 0, 3'd1, 8'd0, 4'd0);
    cyc(1);
    StartBtn = 1'b0;
    LogoutBtn = 1'b0;
    cyc(1);
    doProbe("noGameStart", 0, 0, 0, 3'd1, 8'd0, 4'd0);
    LoggedIn = 1'b0;
    cyc(1);

    // LoggedIn drops during a round: back to IDLE with no logout pulse.
    LoggedIn = 1'b1;
    PlayerID = 3'd4;
    isGuest = 1'b1;
    cyc(1);
    push("startThenDrop", K_GS, 0, 1, 1, 3'd4, 8'd0, 4'd1);
    StartBtn = 1'b1;
    cyc(1);
    StartBtn = 1'b0;
    cyc(2);
    LoggedIn = 1'b0;
    cyc(1);
    doProbe("dropInPlay", 0, 0, 0, 3'd0, 8'd0, 4'd1);
    cyc(3);

    while (expQ.size() > 0) begin
      leftover = expQ.pop_front();
      vectors++;
      miscompares++;
      $display("FAIL %s: got no %s event, need one", leftover.name, kindName(leftover.kind));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
